i3c_sda_pad_ctrl: RTL and testbench

Parametrised, registered SDA pad controller for the I3C target. It replaces the combinational push-pull/open-drain selector with a clocked driver per lane. Each lane provides open-drain or push-pull drive, a guaranteed released-bus turnaround window between drive phases, and a synchronised, optionally glitch-filtered receive path. It sits between the target protocol FSMs and the external tri-state pad cells, which remain outside this block.

---
 rtl/i3c_pad_pkg.sv | 21 ++
 rtl/i3c_pad_rx_filter.sv | 58 +++++
 rtl/i3c_sda_pad_ctrl.sv | 110 +++++++++++
 tb/tb_i3c_sda_pad_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i3c_pad_pkg.sv
// Shared types and constants for the I3C SDA pad controller and its receive lanes.
package i3c_pad_pkg;

  typedef enum logic [1:0] {
    RELEASE = 2'd0,
    DRIVE   = 2'd1,
    TURN    = 2'd2
  } pad_state_t;

  localparam logic MODE_OD  = 1'b0;
  localparam logic MODE_PP  = 1'b1;
  localparam logic SDA_IDLE = 1'b1;

  // Width needed to hold 0..n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/i3c_pad_rx_filter.sv
// One SDA receive lane: 2-FF synchroniser with an optional run-length glitch filter.
// The filter is built only when PAD_RX_FILTER_EN is defined.
module i3c_pad_rx_filter
  import i3c_pad_pkg::*;
#(
  parameter int FILT_DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pad_di,
  output logic sda_rx
);

  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= SDA_IDLE;
      sync2_q <= SDA_IDLE;
    end else begin
      sync1_q <= pad_di;
      sync2_q <= sync1_q;
    end
  end

  if (FILT_DEPTH < 2 || FILT_DEPTH > 8) begin : g_depth_check
    $error("i3c_pad_rx_filter: FILT_DEPTH must be in 2..8");
  end

`ifdef PAD_RX_FILTER_EN
  localparam int RW = $clog2(FILT_DEPTH + 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(FILT_DEPTH - 1);

  logic [RW-1:0] run_q;
  logic          out_q;

  // The run restarts whenever the synchronised value agrees with the output again.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= '0;
      out_q <= SDA_IDLE;
    end else if (sync2_q == out_q) begin
      run_q <= '0;
    end else if (run_q >= RUN_LAST) begin
      out_q <= sync2_q;
      run_q <= '0;
    end else begin
      run_q <= run_q + RW'(1);
    end
  end

  assign sda_rx = out_q;
`else
  assign sda_rx = sync2_q;
`endif

endmodule

// File: rtl/i3c_sda_pad_ctrl.sv
// Registered SDA pad controller: open-drain/push-pull drive with enforced turnaround
// and per-lane synchronised receive (filter enabled by PAD_RX_FILTER_EN).
module i3c_sda_pad_ctrl
  import i3c_pad_pkg::*;
#(
  parameter int LANES      = 1,
  parameter int TURN_CYC   = 2,
  parameter int FILT_DEPTH = 3
) (
  input  logic             i_sys_clk,
  input  logic             i_sys_rst,
  input  logic             i_drive_en,
  input  logic             i_mode_pp,
  input  logic [LANES-1:0] i_sda_data,
  input  logic [LANES-1:0] i_pad_di,
  output logic [LANES-1:0] o_pad_oe,
  output logic [LANES-1:0] o_pad_do,
  output logic [LANES-1:0] o_sda_rx,
  output logic             o_busy,
  output logic             o_turn_done
);

  localparam int CW = cnt_width(TURN_CYC);
  localparam logic [CW-1:0] TURN_LOAD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  pad_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [LANES-1:0] oe_d, do_d;
  logic             turn_done_d;

  // Outputs are derived from the next state so the pad reacts one edge after the request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    oe_d        = '0;
    do_d        = '0;
    turn_done_d = 1'b0;

    case (state_q)
      RELEASE: begin
        if (i_drive_en) begin
          state_d = DRIVE;
          mode_d  = i_mode_pp;
        end
      end
      DRIVE: begin
        if (!i_drive_en) begin
          if (TURN_CYC > 0) begin
            state_d = TURN;
            cnt_d   = TURN_LOAD;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      TURN: begin
        if (cnt_q == '0) begin
          state_d     = RELEASE;
          turn_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RELEASE;
    endcase

    if (state_d == DRIVE) begin
      if (mode_d == MODE_PP) begin
        oe_d = '1;
        do_d = i_sda_data;
      end else begin
        oe_d = ~i_sda_data;
      end
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q     <= RELEASE;
      cnt_q       <= '0;
      mode_q      <= MODE_OD;
      o_pad_oe    <= '0;
      o_pad_do    <= '0;
      o_busy      <= 1'b0;
      o_turn_done <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      o_pad_oe    <= oe_d;
      o_pad_do    <= do_d;
      o_busy      <= (state_d != RELEASE);
      o_turn_done <= turn_done_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_rx
    i3c_pad_rx_filter #(
      .FILT_DEPTH(FILT_DEPTH)
    ) u_rx (
      .clk   (i_sys_clk),
      .rst   (i_sys_rst),
      .pad_di(i_pad_di[g]),
      .sda_rx(o_sda_rx[g])
    );
  end

endmodule

// File: tb/tb_i3c_sda_pad_ctrl.sv
// Directed, table-driven bench for i3c_sda_pad_ctrl (4 lanes, 3-cycle turnaround).
module tb_i3c_sda_pad_ctrl;

  localparam int LANES      = 4;
  localparam int TURN_CYC   = 3;
  localparam int FILT_DEPTH = 3;
`ifdef PAD_RX_FILTER_EN
  localparam int RX_LAT = 2 + FILT_DEPTH;
`else
  localparam int RX_LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             drive_en;
  logic             mode_pp;
  logic [LANES-1:0] sda_data;
  logic [LANES-1:0] pad_di;
  logic [LANES-1:0] pad_oe;
  logic [LANES-1:0] pad_do;
  logic [LANES-1:0] sda_rx;
  logic             busy;
  logic             turn_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i3c_sda_pad_ctrl #(
    .LANES     (LANES),
    .TURN_CYC  (TURN_CYC),
    .FILT_DEPTH(FILT_DEPTH)
  ) dut (
    .i_sys_clk  (clk),
    .i_sys_rst  (rst),
    .i_drive_en (drive_en),
    .i_mode_pp  (mode_pp),
    .i_sda_data (sda_data),
    .i_pad_di   (pad_di),
    .o_pad_oe   (pad_oe),
    .o_pad_do   (pad_do),
    .o_sda_rx   (sda_rx),
    .o_busy     (busy),
    .o_turn_done(turn_done)
  );

  typedef struct {
    logic             en;
    logic             pp;
    logic [LANES-1:0] data;
    logic [LANES-1:0] exp_oe;
    logic [LANES-1:0] exp_do;
    logic             exp_busy;
    logic             exp_td;
  } vec_t;

  vec_t vecs[15];

  task automatic applyStimulus(input logic en, input logic pp, input logic [LANES-1:0] data);
    drive_en = en;
    mode_pp  = pp;
    sda_data = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic runPulse(input int width, output int first_zero, output int zeros);
    first_zero = 0;
    zeros      = 0;
    pad_di     = '0;
    for (int t = 1; t <= 20; t++) begin
      if (t == width + 1) pad_di = '1;
      @(posedge clk);
      #1;
      if (sda_rx == '0) begin
        zeros++;
        if (first_zero == 0) first_zero = t;
      end
    end
  endtask

  initial begin
    int lat;
    int zero_cnt;
    int td_cnt;
    int first_zero;
    int zeros;
    bit seen;

    // drive phase in push-pull, mode change ignored, turnaround, then open-drain phase
    vecs[0]  = '{1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 4'b1010, 4'b1111, 4'b1010, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 4'b1010, 4'b0101, 4'b0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'b0011, 4'b1100, 4'b0000, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

    rst    = 1'b1;
    pad_di = '0;
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("reset_oe", 32'(pad_oe), 32'h0);
    checkOutput("reset_do", 32'(pad_do), 32'h0);
    checkOutput("reset_rx", 32'(sda_rx), 32'hF);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_td", 32'(turn_done), 32'h0);

    rst = 1'b0;
    lat = 0;
    for (int t = 1; t <= 12; t++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (lat == 0 && sda_rx == '0) lat = t;
    end
    checkOutput("rx_fall_latency", 32'(lat), 32'(RX_LAT));

    pad_di = '1;
    for (int t = 0; t < 10; t++) applyStimulus(1'b0, 1'b0, '0);
    checkOutput("rx_idle_high", 32'(sda_rx), 32'hF);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].en, vecs[i].pp, vecs[i].data);
      checkOutput($sformatf("vec%0d_oe", i), 32'(pad_oe), 32'(vecs[i].exp_oe));
      checkOutput($sformatf("vec%0d_do", i), 32'(pad_do), 32'(vecs[i].exp_do));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      checkOutput($sformatf("vec%0d_td", i), 32'(turn_done), 32'(vecs[i].exp_td));
    end

    // drop the request for one cycle, then hold it high through the turnaround
    applyStimulus(1'b1, 1'b1, 4'b1111);
    checkOutput("rearm_drive_oe", 32'(pad_oe), 32'hF);
    applyStimulus(1'b0, 1'b1, 4'b1111);
    zero_cnt = (pad_oe == '0) ? 1 : 0;
    td_cnt   = turn_done ? 1 : 0;
    seen     = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      applyStimulus(1'b1, 1'b1, 4'b1111);
      if (turn_done) td_cnt++;
      if (pad_oe == '0) zero_cnt++;
      else seen = 1'b1;
    end
    checkOutput("rearm_resumed", 32'(seen), 32'h1);
    checkOutput("rearm_oe_zero_cycles", 32'(zero_cnt), 32'(TURN_CYC + 1));
    checkOutput("rearm_td_pulses", 32'(td_cnt), 32'h1);
    checkOutput("rearm_oe", 32'(pad_oe), 32'hF);
    checkOutput("rearm_do", 32'(pad_do), 32'hF);

    // reset in the middle of a drive phase skips the turnaround
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 4'b1111);
    checkOutput("midrst_oe", 32'(pad_oe), 32'h0);
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_rx", 32'(sda_rx), 32'hF);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 4'b1111);
    checkOutput("midrst_after_busy", 32'(busy), 32'h0);
    checkOutput("midrst_after_td", 32'(turn_done), 32'h0);
    for (int t = 0; t < 6; t++) applyStimulus(1'b0, 1'b0, '0);

    runPulse(2, first_zero, zeros);
`ifdef PAD_RX_FILTER_EN
    checkOutput("glitch2_zero_cycles", 32'(zeros), 32'h0);
`else
    checkOutput("glitch2_first_zero", 32'(first_zero), 32'h2);
    checkOutput("glitch2_zero_cycles", 32'(zeros), 32'h2);
`endif
    checkOutput("glitch2_rx_end", 32'(sda_rx), 32'hF);

    runPulse(3, first_zero, zeros);
`ifdef PAD_RX_FILTER_EN
    checkOutput("pulse3_first_zero", 32'(first_zero), 32'h5);
`else
    checkOutput("pulse3_first_zero", 32'(first_zero), 32'h2);
`endif
    checkOutput("pulse3_zero_cycles", 32'(zeros), 32'h3);
    checkOutput("pulse3_rx_end", 32'(sda_rx), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
